// File: rtl/multdiv_scheduler.sv
// rtl/multdiv_scheduler.sv - issue/track/writeback sequencer for the shared mult/div unit
module multdiv_scheduler #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] FD_IR,
    input  logic [31:0] DX_IR,
    input  logic        pw_regWrite,
    input  logic        md_resultRDY,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        md_stall,
    output logic        md_busy,
    output logic        md_wb_en,
    output logic [4:0]  md_wb_rd,
    output logic [31:0] md_wb_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [4:0]  RSTATUS  = 5'd30;
    localparam logic [31:0] EXC_MUL  = 32'd4;
    localparam logic [31:0] EXC_DIV  = 32'd5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t          state, state_n;
    logic [CNT_W-1:0] counter;
    logic [4:0]      p_rd;
    logic            p_div;
    logic [31:0]     r_result;
    logic            r_exc;

    logic            dx_mul, dx_div, fd_md;
    logic [4:0]      dx_rd, fd_rd, fd_rs, fd_rt;
    logic            issue, pending, wb_leave, timeout;
    logic [4:0]      haz_rd;
    logic            haz_hit;

    logic unused_ir_bits;
    assign unused_ir_bits = ^{FD_IR[11:7], FD_IR[1:0], DX_IR[21:7], DX_IR[1:0]};

    // Instruction field decode for the two pipeline stages we watch
    always_comb begin
        dx_mul = (DX_IR[31:27] == 5'b00000) && (DX_IR[6:2] == 5'b00110);
        dx_div = (DX_IR[31:27] == 5'b00000) && (DX_IR[6:2] == 5'b00111);
        fd_md  = (FD_IR[31:27] == 5'b00000) &&
                 ((FD_IR[6:2] == 5'b00110) || (FD_IR[6:2] == 5'b00111));
        dx_rd  = DX_IR[26:22];
        fd_rd  = FD_IR[26:22];
        fd_rs  = FD_IR[21:17];
        fd_rt  = FD_IR[16:12];
    end

    // Issue only from IDLE; a mul/div arriving while busy is dropped without a pulse
    always_comb begin
        issue    = reset_n && (state == IDLE) && (dx_mul || dx_div);
        pending  = reset_n && ((state != IDLE) || issue);
        wb_leave = (state == WB) && !pw_regWrite;
        timeout  = (counter == CNT_LAST);
        haz_rd   = issue ? dx_rd : p_rd;
    end

    // Hazard detection: RAW/WAW on the pending rd, rstatus readers, and structural mul/div
    always_comb begin
        haz_hit = 1'b0;
        if (haz_rd != 5'd0 && (fd_rs == haz_rd || fd_rt == haz_rd || fd_rd == haz_rd))
            haz_hit = 1'b1;
        if (fd_rs == RSTATUS || fd_rt == RSTATUS)
            haz_hit = 1'b1;
        if (fd_md)
            haz_hit = 1'b1;
        // Result becomes visible through the regfile bypass in the writeback cycle
        md_stall = pending && haz_hit && !wb_leave;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (issue) state_n = BUSY;
            BUSY: if (md_resultRDY || timeout) state_n = WB;
            WB:   if (!pw_regWrite) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output decode: unit start pulses and the regfile write request
    always_comb begin
        ctrl_MULT  = issue && dx_mul;
        ctrl_DIV   = issue && dx_div;
        md_busy    = (state != IDLE);
        md_wb_en   = 1'b0;
        md_wb_rd   = 5'd0;
        md_wb_data = 32'd0;
        if (reset_n && state == WB) begin
            if (r_exc) begin
                md_wb_rd   = RSTATUS;
                md_wb_data = p_div ? EXC_DIV : EXC_MUL;
                md_wb_en   = !pw_regWrite;
            end else begin
                md_wb_rd   = p_rd;
                md_wb_data = r_result;
                md_wb_en   = !pw_regWrite && (p_rd != 5'd0);
            end
        end
    end

    // State register plus pending-op holding registers and the BUSY cycle counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            counter  <= '0;
            p_rd     <= 5'd0;
            p_div    <= 1'b0;
            r_result <= 32'd0;
            r_exc    <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (issue) begin
                        p_rd    <= dx_rd;
                        p_div   <= dx_div;
                        counter <= '0;
                        r_exc   <= 1'b0;
                    end
                end
                BUSY: begin
                    counter <= counter + 1'b1;
                    if (md_resultRDY) begin
                        r_result <= md_result;
                        r_exc    <= md_exception;
                    end else if (timeout) begin
                        r_exc <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_scheduler.sv
// tb/tb_multdiv_scheduler.sv - scoreboard bench for multdiv_scheduler
module tb_multdiv_scheduler;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] FD_IR, DX_IR;
    logic        pw_regWrite, md_resultRDY, md_exception;
    logic [31:0] md_result;
    logic        ctrl_MULT, ctrl_DIV, md_stall, md_busy, md_wb_en;
    logic [4:0]  md_wb_rd;
    logic [31:0] md_wb_data;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];

    multdiv_scheduler #(.TIMEOUT_CYCLES(40), .CNT_W(6)) dut (
        .clock(clock), .reset_n(reset_n), .FD_IR(FD_IR), .DX_IR(DX_IR),
        .pw_regWrite(pw_regWrite), .md_resultRDY(md_resultRDY),
        .md_exception(md_exception), .md_result(md_result),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .md_stall(md_stall),
        .md_busy(md_busy), .md_wb_en(md_wb_en), .md_wb_rd(md_wb_rd),
        .md_wb_data(md_wb_data)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] aluop);
        return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Writeback monitor: every md_wb_en must match the oldest expected write
    always @(negedge clock) begin
        if (reset_n === 1'b1 && md_wb_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got rd=%0d data=0x%0h expected no write", md_wb_rd, md_wb_data);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({md_wb_rd, md_wb_data} !== e) begin
                    errors++;
                    $display("FAIL wb_value: got rd=%0d data=0x%0h expected rd=%0d data=0x%0h",
                             md_wb_rd, md_wb_data, e[36:32], e[31:0]);
                end
            end
        end
    end

    // One full operation. k = cycle offset of md_resultRDY after issue (0 = never).
    task automatic run_op(input logic is_div, input logic [4:0] rd, input int k,
                          input logic exc, input logic [31:0] res, input int pw_hold,
                          input logic [31:0] fd, input logic exp_stall, input logic dx_hold,
                          input logic exp_wr, input logic [4:0] exp_rd, input logic [31:0] exp_data);
        logic [31:0] ir;
        ir = rtype(rd, 5'd1, 5'd2, is_div ? 5'd7 : 5'd6);
        FD_IR = fd;
        DX_IR = ir;
        if (exp_wr) exp_q.push_back({exp_rd, exp_data});
        @(negedge clock);
        chk("issue_mult", {31'd0, ctrl_MULT}, {31'd0, !is_div});
        chk("issue_div", {31'd0, ctrl_DIV}, {31'd0, is_div});
        chk("issue_stall", {31'd0, md_stall}, {31'd0, exp_stall});
        step();
        if (!dx_hold) DX_IR = 32'd0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc == k) begin
                md_resultRDY = 1'b1;
                md_exception = exc;
                md_result    = res;
            end
            @(negedge clock);
            checks++;
            if (md_busy !== 1'b1 || ctrl_MULT !== 1'b0 || ctrl_DIV !== 1'b0 ||
                md_wb_en !== 1'b0 || md_stall !== exp_stall) begin
                errors++;
                $display("FAIL busy_cycle%0d: busy=%b mult=%b div=%b wb=%b stall=%b expected 1 0 0 0 %b",
                         cyc, md_busy, ctrl_MULT, ctrl_DIV, md_wb_en, md_stall, exp_stall);
            end
            step();
            md_resultRDY = 1'b0;
            md_exception = 1'b0;
            md_result    = 32'hDEAD_BEEF;
            if (cyc == k) break;
        end
        DX_IR = 32'd0;
        pw_regWrite = 1'b1;
        for (int h = 0; h < pw_hold; h++) begin
            @(negedge clock);
            chk("wb_hold_en", {31'd0, md_wb_en}, 32'd0);
            chk("wb_hold_busy", {31'd0, md_busy}, 32'd1);
            step();
        end
        pw_regWrite = 1'b0;
        @(negedge clock);
        chk("wb_en", {31'd0, md_wb_en}, {31'd0, exp_wr});
        chk("wb_stall", {31'd0, md_stall}, 32'd0);
        step();
        chk("idle_busy", {31'd0, md_busy}, 32'd0);
        FD_IR = 32'd0;
    endtask

    initial begin
        reset_n = 1'b0;
        FD_IR = rtype(5'd6, 5'd5, 5'd1, 5'd0);
        DX_IR = rtype(5'd5, 5'd1, 5'd2, 5'd6);
        pw_regWrite = 1'b0;
        md_resultRDY = 1'b0;
        md_exception = 1'b0;
        md_result = 32'd0;
        step();
        step();
        @(negedge clock);
        chk("rst_mult", {31'd0, ctrl_MULT}, 32'd0);
        chk("rst_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_stall", {31'd0, md_stall}, 32'd0);
        chk("rst_wb", {md_wb_rd, md_wb_data[26:0]}, 32'd0);
        DX_IR = 32'd0;
        FD_IR = 32'd0;
        step();
        reset_n = 1'b1;
        step();

        // mul r5 -> 0x30 at +17
        run_op(1'b0, 5'd5, 17, 1'b0, 32'h30, 0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h30);
        // RAW hazard on r5, also holding a second mul in DX while busy
        run_op(1'b0, 5'd5, 9, 1'b0, 32'h1234, 0, rtype(5'd6, 5'd5, 5'd1, 5'd0), 1'b1, 1'b1,
               1'b1, 5'd5, 32'h1234);
        // Independent add: no stall
        run_op(1'b0, 5'd5, 4, 1'b0, 32'h77, 0, rtype(5'd6, 5'd7, 5'd8, 5'd0), 1'b0, 1'b0,
               1'b1, 5'd5, 32'h77);
        // WAW hazard
        run_op(1'b1, 5'd9, 3, 1'b0, 32'h9, 0, rtype(5'd9, 5'd1, 5'd2, 5'd0), 1'b1, 1'b0,
               1'b1, 5'd9, 32'h9);
        // div r3 exception -> r30=5; FD reads r30 -> stall
        run_op(1'b1, 5'd3, 6, 1'b1, 32'h55, 0, rtype(5'd4, 5'd30, 5'd1, 5'd0), 1'b1, 1'b0,
               1'b1, 5'd30, 32'd5);
        // mul exception -> r30=4; FD is mul/div -> structural stall
        run_op(1'b0, 5'd3, 2, 1'b1, 32'h55, 0, rtype(5'd10, 5'd11, 5'd12, 5'd7), 1'b1, 1'b0,
               1'b1, 5'd30, 32'd4);
        // pw_regWrite blocks writeback for 3 cycles
        run_op(1'b0, 5'd12, 5, 1'b0, 32'hCAFE_0001, 3, 32'd0, 1'b0, 1'b0,
               1'b1, 5'd12, 32'hCAFE_0001);
        // Timeout: never ready -> forced exception
        run_op(1'b1, 5'd8, 0, 1'b0, 32'd0, 0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd30, 32'd5);
        // Ready on the 40th BUSY cycle wins over timeout
        run_op(1'b0, 5'd8, 40, 1'b0, 32'hABCD, 0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd8, 32'hABCD);
        // rd=0: no write, FSM still returns to IDLE
        run_op(1'b0, 5'd0, 3, 1'b0, 32'h11, 0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        // Reset during BUSY drops the op
        DX_IR = rtype(5'd7, 5'd1, 5'd2, 5'd6);
        step();
        DX_IR = 32'd0;
        step();
        step();
        @(negedge clock);
        chk("mid_busy", {31'd0, md_busy}, 32'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        md_resultRDY = 1'b1;
        md_result = 32'h99;
        FD_IR = rtype(5'd1, 5'd2, 5'd3, 5'd6);
        @(negedge clock);
        chk("postrst_busy", {31'd0, md_busy}, 32'd0);
        chk("postrst_stall", {31'd0, md_stall}, 32'd0);
        step();
        md_resultRDY = 1'b0;
        @(negedge clock);
        chk("postrst_wb", {31'd0, md_wb_en}, 32'd0);
        chk("postrst_busy2", {31'd0, md_busy}, 32'd0);
        step();
        step();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
